// File: rtl/tlp_snoop_arb.sv
// tlp_snoop_arb
// Shares one downstream snoop FIFO between the RX (source 0) and TX
// (source 1) TLP snoop FIFOs. Whole packets are moved beat by beat, never
// interleaved, arbitrated round-robin at packet boundaries, and tagged with
// their source and a global sequence number. A watchdog aborts a packet whose
// source runs dry mid-packet, emits a terminator beat and flushes the rest.
//
// Beat layout (PCIE_FIFO64_RX): [TVALID_BIT] tvalid, [TLAST_BIT] tlast,
// [63:0] payload.
module tlp_snoop_arb #(
   parameter int TIMEOUT    = 500,
   parameter int SEQ_W      = 16,
   parameter int FIFO_W     = 66,
   parameter int TLAST_BIT  = 64,
   parameter int TVALID_BIT = 65
) (
   input  logic              pcie_clk,
   input  logic              pcie_rst,
   input  logic [1:0]        cfg_en,
   output logic              src0_rd_en,
   output logic              src1_rd_en,
   input  logic [FIFO_W-1:0] src0_dout,
   input  logic [FIFO_W-1:0] src1_dout,
   input  logic              src0_empty,
   input  logic              src1_empty,
   output logic              wr_en,
   output logic [FIFO_W-1:0] din,
   input  logic              full,
   output logic              out_src,
   output logic [SEQ_W-1:0]  out_seq,
   output logic [31:0]       pkt_cnt0,
   output logic [31:0]       pkt_cnt1,
   output logic [15:0]       abort_cnt
);

   // Watchdog is at least 10 bits and wide enough to reach TIMEOUT.
   localparam int WD_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_ABORT = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic               sel_r;
   logic               last_r;
   logic [SEQ_W-1:0]   seq_cnt_r;
   logic [WD_W-1:0]    wd_cnt_r;

   logic [1:0]         elig_s;
   logic               grant_s;
   logic               grant_src_s;
   logic               sel_empty_s;
   logic [FIFO_W-1:0]  sel_dout_s;
   logic               sel_tlast_s;
   logic               timeout_s;
   logic               xfer_beat_s;
   logic               flush_pop_s;
   logic               abort_wr_s;
   logic [FIFO_W-1:0]  term_beat_s;

   // Arbitration, selected-source mux and per-state transfer qualifiers.
   always_comb begin
      elig_s      = cfg_en & {~src1_empty, ~src0_empty};
      grant_s     = 1'b0;
      grant_src_s = 1'b0;
      if (state_r == ST_IDLE) begin
         case (elig_s)
            2'b01: begin
               grant_s     = 1'b1;
               grant_src_s = 1'b0;
            end
            2'b10: begin
               grant_s     = 1'b1;
               grant_src_s = 1'b1;
            end
            2'b11: begin
               grant_s     = 1'b1;
               grant_src_s = ~last_r;
            end
            default: begin
               grant_s     = 1'b0;
               grant_src_s = 1'b0;
            end
         endcase
      end else begin
         grant_s     = 1'b0;
         grant_src_s = 1'b0;
      end

      if (sel_r) begin
         sel_empty_s = src1_empty;
         sel_dout_s  = src1_dout;
      end else begin
         sel_empty_s = src0_empty;
         sel_dout_s  = src0_dout;
      end

      sel_tlast_s = sel_dout_s[TLAST_BIT];
      timeout_s   = (wd_cnt_r == WD_W'(TIMEOUT));
      xfer_beat_s = (state_r == ST_XFER)  && !timeout_s && !sel_empty_s && !full;
      flush_pop_s = (state_r == ST_FLUSH) && !timeout_s && !sel_empty_s;
      abort_wr_s  = (state_r == ST_ABORT) && !full;

      term_beat_s             = {FIFO_W{1'b0}};
      term_beat_s[TLAST_BIT]  = 1'b1;
      term_beat_s[TVALID_BIT] = 1'b0;
   end

   // FSM state register.
   always_ff @(posedge pcie_clk) begin
      if (pcie_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_s) begin
               state_s = ST_XFER;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_XFER: begin
            if (timeout_s) begin
               state_s = ST_ABORT;
            end else if (xfer_beat_s && sel_tlast_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_XFER;
            end
         end
         ST_ABORT: begin
            if (abort_wr_s) begin
               state_s = ST_FLUSH;
            end else begin
               state_s = ST_ABORT;
            end
         end
         ST_FLUSH: begin
            if (timeout_s) begin
               state_s = ST_IDLE;
            end else if (flush_pop_s && sel_tlast_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_FLUSH;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: FIFO strobes and downstream beat, combinational so a beat
   // moves in the cycle it is accepted; din is zero whenever nothing is written.
   always_comb begin
      src0_rd_en = 1'b0;
      src1_rd_en = 1'b0;
      wr_en      = 1'b0;
      din        = {FIFO_W{1'b0}};
      case (state_r)
         ST_XFER: begin
            if (xfer_beat_s) begin
               src0_rd_en = ~sel_r;
               src1_rd_en = sel_r;
               wr_en      = 1'b1;
               din        = sel_dout_s;
            end else begin
               wr_en      = 1'b0;
            end
         end
         ST_ABORT: begin
            if (abort_wr_s) begin
               wr_en = 1'b1;
               din   = term_beat_s;
            end else begin
               wr_en = 1'b0;
            end
         end
         ST_FLUSH: begin
            if (flush_pop_s) begin
               src0_rd_en = ~sel_r;
               src1_rd_en = sel_r;
            end else begin
               src0_rd_en = 1'b0;
               src1_rd_en = 1'b0;
            end
         end
         default: begin
            wr_en = 1'b0;
         end
      endcase
   end

   // Grant bookkeeping: selected source, round-robin history, packet tags.
   always_ff @(posedge pcie_clk) begin
      if (pcie_rst) begin
         sel_r     <= 1'b0;
         last_r    <= 1'b1;
         seq_cnt_r <= {SEQ_W{1'b0}};
         out_src   <= 1'b0;
         out_seq   <= {SEQ_W{1'b0}};
      end else if (grant_s) begin
         sel_r     <= grant_src_s;
         last_r    <= grant_src_s;
         out_src   <= grant_src_s;
         out_seq   <= seq_cnt_r;
         seq_cnt_r <= seq_cnt_r + SEQ_W'(1);
      end
   end

   // Completed-packet and abort statistics.
   always_ff @(posedge pcie_clk) begin
      if (pcie_rst) begin
         pkt_cnt0  <= 32'd0;
         pkt_cnt1  <= 32'd0;
         abort_cnt <= 16'd0;
      end else begin
         if (xfer_beat_s && sel_tlast_s) begin
            if (sel_r) begin
               pkt_cnt1 <= pkt_cnt1 + 32'd1;
            end else begin
               pkt_cnt0 <= pkt_cnt0 + 32'd1;
            end
         end
         if ((state_r == ST_XFER) && timeout_s && (abort_cnt != 16'hFFFF)) begin
            abort_cnt <= abort_cnt + 16'd1;
         end
      end
   end

   // Watchdog: counts source-empty cycles mid-packet; backpressure from
   // full never advances it.
   always_ff @(posedge pcie_clk) begin
      if (pcie_rst) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else if (grant_s) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else begin
         case (state_r)
            ST_XFER: begin
               if (xfer_beat_s) begin
                  wd_cnt_r <= {WD_W{1'b0}};
               end else if (!timeout_s && sel_empty_s) begin
                  wd_cnt_r <= wd_cnt_r + WD_W'(1);
               end
            end
            ST_ABORT: begin
               if (abort_wr_s) begin
                  wd_cnt_r <= {WD_W{1'b0}};
               end
            end
            ST_FLUSH: begin
               if (flush_pop_s) begin
                  wd_cnt_r <= {WD_W{1'b0}};
               end else if (!timeout_s && sel_empty_s) begin
                  wd_cnt_r <= wd_cnt_r + WD_W'(1);
               end
            end
            default: begin
               wd_cnt_r <= wd_cnt_r;
            end
         endcase
      end
   end

endmodule
